// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for the 1x3 router input port.
// Buffers a payload, then sends header, payload and parity to the router,
// stalling on busy, and samples the router error line after parity.
// Optional build macro ROUTER_TX_PARITY_INJECT_EN adds inject_err, which
// makes the transmitted parity byte the inverse of the computed parity.
//
// state | meaning
// IDLE  | waiting for a legal start; illegal requests pulse reject
// LOAD  | collecting pay_len payload bytes into the buffer
// HDR   | driving the header byte {pay_len, dest_addr}
// PAY   | driving buffered payload bytes in order
// PAR   | driving the parity byte (pkt_valid low)
// CHK   | sampling router error for ERR_WAIT cycles, then done
module router_pkt_tx #(
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
    input  logic [7:0] pay_data,
    input  logic       pay_valid,
    output logic       pay_ready,
    input  logic       busy,
    input  logic       error,
`ifdef ROUTER_TX_PARITY_INJECT_EN
    input  logic       inject_err,
`endif
    output logic       pkt_valid,
    output logic [7:0] tx_data,
    output logic       tx_active,
    output logic       done,
    output logic       err_flag,
    output logic       reject
);

    typedef enum logic [2:0] {IDLE, LOAD, HDR, PAY, PAR, CHK} state_t;

    localparam logic [5:0] MAX_LEN_L = 6'(MAX_LEN);
    localparam logic [7:0] WAIT_LAST = 8'(ERR_WAIT - 1);

    state_t     state, state_nxt;
    logic [1:0] dest_q;
    logic [5:0] len_q;
    logic [5:0] ptr;
    logic [7:0] parity;
    logic [7:0] wait_cnt;
    logic       inj_q;
    logic [7:0] buf_mem [0:MAX_LEN-1];
    logic [7:0] header;
    logic [5:0] len_m1;
    logic       legal;
    logic       start_seen;

    assign header     = {len_q, dest_q};
    assign len_m1     = len_q - 6'd1;
    assign legal      = (dest_addr != 2'd3) && (pay_len != 6'd0) && (pay_len <= MAX_LEN_L);
    // done marks IDLE's first cycle; a start there is not taken
    assign start_seen = start && !done;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and router-side outputs
    always_comb begin
        state_nxt = state;
        pay_ready = 1'b0;
        pkt_valid = 1'b0;
        tx_data   = 8'h00;
        tx_active = (state != IDLE);
        case (state)
            IDLE: if (start_seen && legal) state_nxt = LOAD;
            LOAD: begin
                pay_ready = 1'b1;
                if (pay_valid && ptr == len_m1) state_nxt = HDR;
            end
            HDR: begin
                pkt_valid = 1'b1;
                tx_data   = header;
                if (!busy) state_nxt = PAY;
            end
            PAY: begin
                pkt_valid = 1'b1;
                tx_data   = buf_mem[ptr];
                if (!busy && ptr == len_m1) state_nxt = PAR;
            end
            PAR: begin
                tx_data = inj_q ? ~parity : parity;
                if (!busy) state_nxt = CHK;
            end
            CHK: if (wait_cnt == WAIT_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, pointers, parity accumulation and status pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dest_q   <= 2'd0;
            len_q    <= 6'd0;
            ptr      <= 6'd0;
            parity   <= 8'h00;
            wait_cnt <= 8'd0;
            inj_q    <= 1'b0;
            done     <= 1'b0;
            err_flag <= 1'b0;
            reject   <= 1'b0;
        end else begin
            done   <= 1'b0;
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_seen) begin
                        if (legal) begin
                            dest_q   <= dest_addr;
                            len_q    <= pay_len;
                            err_flag <= 1'b0;
                            parity   <= 8'h00;
                            ptr      <= 6'd0;
`ifdef ROUTER_TX_PARITY_INJECT_EN
                            inj_q    <= inject_err;
`else
                            inj_q    <= 1'b0;
`endif
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (pay_valid) begin
                        parity <= parity ^ pay_data;
                        ptr    <= ptr + 6'd1;
                    end
                end
                HDR: begin
                    if (!busy) begin
                        parity <= parity ^ header;
                        ptr    <= 6'd0;
                    end
                end
                PAY: if (!busy) ptr <= ptr + 6'd1;
                PAR: if (!busy) wait_cnt <= 8'd0;
                CHK: begin
                    if (error) err_flag <= 1'b1;
                    wait_cnt <= wait_cnt + 8'd1;
                    if (wait_cnt == WAIT_LAST) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Payload buffer write; contents need no reset
    always_ff @(posedge clk) begin
        if (state == LOAD && pay_valid) buf_mem[ptr] <= pay_data;
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus pushes expected bytes, status
// and timing into queues; a negedge monitor pops and compares them.
module tb_router_pkt_tx;

    localparam int ERR_WAIT = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_ready;
    logic       busy;
    logic       error;
`ifdef ROUTER_TX_PARITY_INJECT_EN
    logic       inject_err;
`endif
    logic       pkt_valid;
    logic [7:0] tx_data;
    logic       tx_active;
    logic       done;
    logic       err_flag;
    logic       reject;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] exp_q [$];
    logic       err_q [$];
    int         dur_q [$];
    logic [7:0] pay_buf [0:62];

    router_pkt_tx #(.MAX_LEN(63), .ERR_WAIT(ERR_WAIT)) dut (
        .clk(clk), .resetn(resetn), .start(start), .dest_addr(dest_addr),
        .pay_len(pay_len), .pay_data(pay_data), .pay_valid(pay_valid),
        .pay_ready(pay_ready), .busy(busy), .error(error),
`ifdef ROUTER_TX_PARITY_INJECT_EN
        .inject_err(inject_err),
`endif
        .pkt_valid(pkt_valid), .tx_data(tx_data), .tx_active(tx_active),
        .done(done), .err_flag(err_flag), .reject(reject)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, got, want);
        end
    endtask

    // Monitor: router-side byte acceptance, stall hold, done status/timing
    logic       in_pkt = 1'b0, prev_ok = 1'b0, prev_busy = 1'b0, prev_pv = 1'b0, prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         hdr_cyc = 0, par_cyc = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            in_pkt  = 1'b0;
            prev_ok = 1'b0;
        end else begin
            if (prev_ok && prev_busy && in_pkt && tx_active) begin
                check("hold_tx_data", tx_data, prev_data);
                check("hold_pkt_valid", {7'd0, pkt_valid}, {7'd0, prev_pv});
            end
            if (pkt_valid && !in_pkt) begin
                in_pkt  = 1'b1;
                hdr_cyc = cyc;
            end
            if ((pkt_valid || (in_pkt && tx_active)) && !busy) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_byte: got %02h pkt_valid=%0d, expected no transfer", tx_data, pkt_valid);
                end else begin
                    check(pkt_valid ? "tx_byte" : "parity_byte", tx_data, exp_q.pop_front());
                end
                if (!pkt_valid) begin
                    in_pkt  = 1'b0;
                    par_cyc = cyc;
                    if (dur_q.size() != 0)
                        check("hdr_to_par_cycles", 8'(cyc - hdr_cyc), 8'(dur_q.pop_front()));
                end
            end
            if (done) begin
                if (err_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done: got unexpected done pulse, expected none");
                end else begin
                    check("err_flag_at_done", {7'd0, err_flag}, {7'd0, err_q.pop_front()});
                    check("done_latency", 8'(cyc - par_cyc), 8'(ERR_WAIT + 1));
                end
                if (prev_done) check("done_width", 8'd2, 8'd1);
            end
            prev_ok   = 1'b1;
            prev_busy = busy;
            prev_pv   = pkt_valid;
            prev_data = tx_data;
            prev_done = done;
        end
    end

    // One packet: expectations pushed, then start, payload load and router side
    task automatic send_pkt(input logic [1:0] d, input logic [5:0] l, input bit gap,
                            input int stall_at, input int stall_len, input int err_at,
                            input bit exp_err, input bit inj, input int rst_at);
        logic [7:0] seq [$];
        logic [7:0] par;
        int idx, off;
        par = {l, d};
        seq.push_back(par);
        for (int i = 0; i < int'(l); i++) begin
            seq.push_back(pay_buf[i]);
            par = par ^ pay_buf[i];
        end
`ifdef ROUTER_TX_PARITY_INJECT_EN
        if (inj) par = ~par;
`endif
        seq.push_back(par);
        if (rst_at >= 0) begin
            for (int i = 0; i < rst_at; i++) exp_q.push_back(seq[i]);
        end else begin
            foreach (seq[i]) exp_q.push_back(seq[i]);
            err_q.push_back(exp_err);
            dur_q.push_back(int'(l) + 1 + stall_len);
        end

        start = 1'b1; dest_addr = d; pay_len = l;
`ifdef ROUTER_TX_PARITY_INJECT_EN
        inject_err = inj;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        check("start_clears_err_flag", {7'd0, err_flag}, 8'd0);
        check("load_pay_ready", {7'd0, pay_ready}, 8'd1);
        check("load_tx_active", {7'd0, tx_active}, 8'd1);

        idx = 0;
        for (int c = 0; c < int'(l) * (gap ? 2 : 1); c++) begin
            if (gap && (c % 2 == 0)) begin
                pay_valid = 1'b0;
            end else begin
                pay_valid = 1'b1;
                pay_data  = pay_buf[idx];
                idx++;
            end
            @(posedge clk); #1;
        end
        pay_valid = 1'b0;

        off = 0;
        forever begin
            busy  = (off >= stall_at) && (off < stall_at + stall_len);
            error = (off == err_at);
            if (off == rst_at) begin
                resetn = 1'b0;
                @(posedge clk); #1;
                check("rst_pkt_valid", {7'd0, pkt_valid}, 8'd0);
                check("rst_tx_active", {7'd0, tx_active}, 8'd0);
                resetn = 1'b1; busy = 1'b0; error = 1'b0;
                return;
            end
            @(posedge clk); #1;
            off++;
            if (done) break;
            if (off > 400) begin
                checks++; errors++;
                $display("FAIL done_timeout: got no done after %0d cycles, expected done", off);
                break;
            end
        end
        busy = 1'b0; error = 1'b0;
        // A legal start in done's cycle must be ignored
        start = 1'b1; dest_addr = 2'd0; pay_len = 6'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_with_done_ignored", {7'd0, tx_active}, 8'd0);
    endtask

    task automatic try_reject(input logic [1:0] d, input logic [5:0] l);
        start = 1'b1; dest_addr = d; pay_len = l;
        @(posedge clk); #1;
        start = 1'b0;
        check("reject_pulse", {7'd0, reject}, 8'd1);
        check("reject_tx_active", {7'd0, tx_active}, 8'd0);
        @(posedge clk); #1;
        check("reject_one_cycle", {7'd0, reject}, 8'd0);
        check("reject_idle", {7'd0, tx_active}, 8'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; dest_addr = 2'd0; pay_len = 6'd0;
        pay_data = 8'h00; pay_valid = 1'b0; busy = 1'b0; error = 1'b0;
`ifdef ROUTER_TX_PARITY_INJECT_EN
        inject_err = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_pkt_valid", {7'd0, pkt_valid}, 8'd0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_pay_ready", {7'd0, pay_ready}, 8'd0);
        check("rst_tx_active", {7'd0, tx_active}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_err_flag", {7'd0, err_flag}, 8'd0);
        check("rst_reject", {7'd0, reject}, 8'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // dest 1, 2 bytes: 09 A5 3C 90 (6F with parity injection)
        pay_buf[0] = 8'hA5; pay_buf[1] = 8'h3C;
        send_pkt(2'd1, 6'd2, 1'b0, -1, 0, -1, 1'b0, 1'b1, -1);
        // Same packet, 4-cycle stall while A5 is driven
        send_pkt(2'd1, 6'd2, 1'b0, 1, 4, -1, 1'b0, 1'b0, -1);

        try_reject(2'd3, 6'd2);
        try_reject(2'd0, 6'd0);

        // Maximum length, pay_valid every other cycle
        for (int i = 0; i < 63; i++) pay_buf[i] = 8'(i * 37 + 11);
        send_pkt(2'd2, 6'd63, 1'b1, -1, 0, -1, 1'b0, 1'b0, -1);

        // Router error in the 2nd CHK cycle, then error outside CHK ignored
        pay_buf[0] = 8'h5A; pay_buf[1] = 8'hC3;
        send_pkt(2'd0, 6'd2, 1'b0, -1, 0, 5, 1'b1, 1'b0, -1);
        send_pkt(2'd2, 6'd2, 1'b0, -1, 0, 1, 1'b0, 1'b0, -1);

        // Reset while payload byte 1 of 3 is driven, then a clean packet
        pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h44;
        send_pkt(2'd1, 6'd3, 1'b0, -1, 0, -1, 1'b0, 1'b0, 2);
        send_pkt(2'd0, 6'd3, 1'b0, 2, 2, -1, 1'b0, 1'b0, -1);

        repeat (5) @(posedge clk);
        #1;
        check("bytes_left_unsent", 8'(exp_q.size()), 8'd0);
        check("done_left_unseen", 8'(err_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
